// File: rtl/dct8_stream_mac.sv
// dct8_stream_mac: sample-serial 8-point DCT-II (forward) / DCT-III (inverse), 8 MAC lanes, double-buffered output.
// Latency: word 0 is valid the cycle after the 8th input handshake; sustains 1 sample/cycle in, 1 word/cycle out.
// Backpressure: in_ready drops only for the 8th sample of a block while the output buffer is full and not finishing its last word.
// Build option DCT8_STREAM_SAT_EN: clamp results to DATA_W and flag sat_o per word; otherwise results wrap and sat_o is 0.
module dct8_stream_mac #(
    parameter int DATA_W  = 16,
    parameter int CONST_W = 16,
    parameter int FRAC    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_inv,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [2:0]        out_idx,
    output logic              out_last,
    output logic              sat_o
);
    localparam int PROD_W = DATA_W + CONST_W;
    localparam int ACC_W  = PROD_W + 3;

    // cos(j*pi/16) in Q30, j = 0..8
    function automatic logic signed [63:0] cos_q30(input int j);
        case (j)
            0:       return 64'sd1073741824;
            1:       return 64'sd1053110176;
            2:       return 64'sd992008094;
            3:       return 64'sd892783698;
            4:       return 64'sd759250125;
            5:       return 64'sd596538995;
            6:       return 64'sd410903207;
            7:       return 64'sd209476638;
            default: return 64'sd0;
        endcase
    endfunction

    // Entry (k*8+n) holds C[k][n]; c(k)/2*cos is the Q30 cosine read as Q31, k=0 uses cos(pi/4).
    function automatic logic [64*CONST_W-1:0] rom_init();
        logic [64*CONST_W-1:0] rom;
        logic signed [63:0]    v;
        logic signed [63:0]    mag;
        int                    a;
        rom = '0;
        for (int k = 0; k < 8; k++) begin
            for (int n = 0; n < 8; n++) begin
                a = ((2 * n + 1) * k) % 32;
                if (k == 0)       v = cos_q30(4);
                else if (a <= 8)  v = cos_q30(a);
                else if (a <= 16) v = -cos_q30(16 - a);
                else if (a <= 24) v = -cos_q30(a - 16);
                else              v = cos_q30(32 - a);
                mag = (v < 0) ? -v : v;
                mag = ((mag <<< FRAC) + 64'sd1073741824) >>> 31;
                if (v < 0) mag = -mag;
                rom[(k * 8 + n) * CONST_W +: CONST_W] = mag[CONST_W-1:0];
            end
        end
        return rom;
    endfunction

    localparam logic [64*CONST_W-1:0] ROM = rom_init();

    logic [2:0]               cnt;
    logic                     mode_q;
    logic                     mode_cur;
    logic                     in_hs;
    logic                     out_hs;
    logic signed [PROD_W-1:0] data_ext;
    logic signed [CONST_W-1:0] coef     [8];
    logic signed [PROD_W-1:0] prod     [8];
    logic signed [ACC_W-1:0]  acc      [8];
    logic signed [ACC_W-1:0]  acc_base [8];
    logic signed [ACC_W-1:0]  acc_next [8];
    logic [DATA_W-1:0]        res      [8];
    logic [DATA_W-1:0]        obuf     [8];
    logic                     obuf_valid;
    logic [2:0]               rd_idx;
`ifdef DCT8_STREAM_SAT_EN
    localparam int RND_W = ACC_W - FRAC + 1;
    localparam logic signed [RND_W-1:0] MAXV = {{(RND_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [RND_W-1:0] MINV = {{(RND_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    logic signed [RND_W-1:0]  rnd      [8];
    logic [7:0]               res_sat;
    logic [7:0]               obuf_sat;
`endif

    assign out_hs    = out_valid && out_ready;
    assign in_ready  = (cnt != 3'd7) || !obuf_valid || (out_hs && out_last);
    assign in_hs     = in_valid && in_ready;
    assign out_valid = obuf_valid;
    assign out_data  = obuf[rd_idx];
    assign out_idx   = rd_idx;
    assign out_last  = obuf_valid && (rd_idx == 3'd7);
`ifdef DCT8_STREAM_SAT_EN
    assign sat_o     = obuf_valid && obuf_sat[rd_idx];
`else
    assign sat_o     = 1'b0;
`endif

    always_comb begin
        mode_cur = (cnt == 3'd0) ? in_inv : mode_q;
        data_ext = $signed({{CONST_W{in_data[DATA_W-1]}}, in_data});
`ifdef DCT8_STREAM_SAT_EN
        res_sat  = '0;
`endif
        for (int i = 0; i < 8; i++) begin
            // Lane i owns output index i: forward walks C[i][cnt], inverse walks C[cnt][i].
            if (mode_cur) coef[i] = ROM[(int'(cnt) * 8 + i) * CONST_W +: CONST_W];
            else          coef[i] = ROM[(i * 8 + int'(cnt)) * CONST_W +: CONST_W];
            prod[i] = $signed({{DATA_W{coef[i][CONST_W-1]}}, coef[i]}) * data_ext;
            if (cnt == 3'd0) acc_base[i] = '0;
            else             acc_base[i] = acc[i];
            acc_next[i] = acc_base[i] + $signed({{3{prod[i][PROD_W-1]}}, prod[i]});
            // (a + 2^(F-1)) >>> F == (a >>> F) + a[F-1]
`ifdef DCT8_STREAM_SAT_EN
            rnd[i] = $signed({acc_next[i][ACC_W-1], acc_next[i][ACC_W-1:FRAC]})
                   + $signed({{(RND_W-1){1'b0}}, acc_next[i][FRAC-1]});
            if (rnd[i] > MAXV) begin
                res[i]     = {1'b0, {(DATA_W-1){1'b1}}};
                res_sat[i] = 1'b1;
            end else if (rnd[i] < MINV) begin
                res[i]     = {1'b1, {(DATA_W-1){1'b0}}};
                res_sat[i] = 1'b1;
            end else begin
                res[i]     = rnd[i][DATA_W-1:0];
            end
`else
            res[i] = acc_next[i][FRAC +: DATA_W] + {{(DATA_W-1){1'b0}}, acc_next[i][FRAC-1]};
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= 3'd0;
            mode_q     <= 1'b0;
            obuf_valid <= 1'b0;
            rd_idx     <= 3'd0;
            for (int i = 0; i < 8; i++) begin
                acc[i]  <= '0;
                obuf[i] <= '0;
            end
`ifdef DCT8_STREAM_SAT_EN
            obuf_sat   <= '0;
`endif
        end else begin
            if (in_hs) begin
                cnt <= cnt + 3'd1;
                if (cnt == 3'd0) mode_q <= in_inv;
                for (int i = 0; i < 8; i++) acc[i] <= acc_next[i];
            end
            if (out_hs) begin
                rd_idx <= rd_idx + 3'd1;
                if (rd_idx == 3'd7) obuf_valid <= 1'b0;
            end
            // A load in the same cycle as the final drain wins, giving gap-free output.
            if (in_hs && (cnt == 3'd7)) begin
                obuf_valid <= 1'b1;
                rd_idx     <= 3'd0;
                for (int i = 0; i < 8; i++) obuf[i] <= res[i];
`ifdef DCT8_STREAM_SAT_EN
                obuf_sat   <= res_sat;
`endif
            end
        end
    end
endmodule

// File: tb/tb_dct8_stream_mac.sv
// tb_dct8_stream_mac: directed and randomized blocks for dct8_stream_mac, scored against a real-math DCT model.
module tb_dct8_stream_mac;
    localparam int DATA_W  = 16;
    localparam int CONST_W = 16;
    localparam int FRAC    = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_inv = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic [2:0]        out_idx;
    logic              out_last;
    logic              sat_o;

    dct8_stream_mac #(.DATA_W(DATA_W), .CONST_W(CONST_W), .FRAC(FRAC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_inv    (in_inv),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .sat_o     (sat_o)
    );

    always #5 clk = ~clk;

    typedef struct { logic [DATA_W-1:0] d; logic inv; } smp_t;
    typedef struct { logic [DATA_W-1:0] d; logic s; } exp_t;

    smp_t in_q [$];
    exp_t exp_q [$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   in_prob = 100;
    int   out_prob = 100;
    int   exp_idx = 0;
    int   imp_f [8] = '{91, 126, 118, 106, 91, 71, 49, 25};
    logic [DATA_W-1:0] blk [8];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint coef(int k, int n);
        real ck, v;
        ck = (k == 0) ? 1.0 / $sqrt(2.0) : 1.0;
        v  = (2.0 ** FRAC) * ck / 2.0 * $cos(real'((2 * n + 1) * k) * 3.14159265358979 / 16.0);
        if (v >= 0.0) return longint'($floor(v + 0.5));
        else          return -longint'($floor(-v + 0.5));
    endfunction

    // Only the first sample's in_inv matters; the rest carry random noise.
    task automatic add_samples(input logic inv, input logic [DATA_W-1:0] s [8]);
        smp_t e;
        for (int j = 0; j < 8; j++) begin
            e.d   = s[j];
            e.inv = (j == 0) ? inv : 1'($urandom);
            in_q.push_back(e);
        end
    endtask

    task automatic push_exp(input logic [DATA_W-1:0] d, input logic s);
        exp_t e;
        e.d = d;
        e.s = s;
        exp_q.push_back(e);
    endtask

    task automatic add_model(input logic inv, input logic [DATA_W-1:0] s [8]);
        longint acc, r;
        for (int o = 0; o < 8; o++) begin
            acc = 0;
            for (int j = 0; j < 8; j++)
                acc += (inv ? coef(j, o) : coef(o, j)) * longint'($signed(s[j]));
            r = (acc + (longint'(1) << (FRAC - 1))) >>> FRAC;
`ifdef DCT8_STREAM_SAT_EN
            if (r > 32767)       push_exp(16'h7fff, 1'b1);
            else if (r < -32768) push_exp(16'h8000, 1'b1);
            else                 push_exp(r[DATA_W-1:0], 1'b0);
`else
            push_exp(r[DATA_W-1:0], 1'b0);
`endif
        end
    endtask

    task automatic drive();
        if (in_q.size() > 0 && $urandom_range(99) < in_prob) begin
            in_valid = 1'b1;
            in_data  = in_q[0].d;
            in_inv   = in_q[0].inv;
        end else begin
            in_valid = 1'b0;
            in_data  = 16'($urandom);
            in_inv   = 1'($urandom);
        end
        out_ready = ($urandom_range(99) < out_prob);
    endtask

    // Check outputs at negedge, let the posedge happen, then retire handshakes and redrive.
    task automatic run_cycle();
        logic ih, oh;
        @(negedge clk);
        ih = in_valid && in_ready;
        oh = out_valid && out_ready;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_out_valid", out_valid, 0);
            end else begin
                check_eq("out_data", out_data, exp_q[0].d);
                check_eq("out_idx", out_idx, exp_idx);
                check_eq("out_last", out_last, exp_idx == 7);
                check_eq("sat_o", sat_o, exp_q[0].s);
            end
        end
        @(posedge clk);
        #1;
        if (ih) void'(in_q.pop_front());
        if (oh && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            exp_idx = (exp_idx + 1) % 8;
        end
        drive();
    endtask

    task automatic run_idle(input int bound);
        int c = 0;
        while ((in_q.size() > 0 || exp_q.size() > 0) && c < bound) begin
            run_cycle();
            c++;
        end
        check_eq("drained", in_q.size() + exp_q.size(), 0);
    endtask

    task automatic check_reset_vals();
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_out_idx", out_idx, 0);
        check_eq("rst_out_last", out_last, 0);
        check_eq("rst_sat_o", sat_o, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        #1 rst_n = 1'b0;
        #1 check_reset_vals();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        drive();

        // DC forward, with latency check
        for (int j = 0; j < 8; j++) blk[j] = 16'd100;
        add_samples(1'b0, blk);
        push_exp(16'd284, 1'b0);
        for (int j = 1; j < 8; j++) push_exp(16'd0, 1'b0);
        drive();
        for (int c = 0; c < 50 && in_q.size() > 0; c++) begin
            check_eq("dc_early_valid", out_valid, 0);
            run_cycle();
        end
        check_eq("dc_latency_valid", out_valid, 1);
        check_eq("dc_latency_idx", out_idx, 0);
        run_idle(100);

        // Forward impulse
        blk[0] = 16'd256;
        for (int j = 1; j < 8; j++) blk[j] = 16'd0;
        add_samples(1'b0, blk);
        for (int j = 0; j < 8; j++) push_exp(16'(imp_f[j]), 1'b0);
        run_idle(100);

        // Inverse impulse immediately followed by forward impulse
        add_samples(1'b1, blk);
        for (int j = 0; j < 8; j++) push_exp(16'd91, 1'b0);
        add_samples(1'b0, blk);
        for (int j = 0; j < 8; j++) push_exp(16'(imp_f[j]), 1'b0);
        run_idle(100);

        // Overflow
        for (int j = 0; j < 8; j++) blk[j] = 16'd32767;
        add_samples(1'b0, blk);
`ifdef DCT8_STREAM_SAT_EN
        push_exp(16'd32767, 1'b1);
`else
        push_exp(16'd27645, 1'b0);
`endif
        for (int j = 1; j < 8; j++) push_exp(16'd0, 1'b0);
        run_idle(100);

        // Backpressure: two DC blocks with out_ready held low
        out_prob = 0;
        for (int j = 0; j < 8; j++) blk[j] = 16'd100;
        for (int b = 0; b < 2; b++) begin
            add_samples(1'b0, blk);
            push_exp(16'd284, 1'b0);
            for (int j = 1; j < 8; j++) push_exp(16'd0, 1'b0);
        end
        drive();
        repeat (20) run_cycle();
        check_eq("bp_in_ready_low", in_ready, 0);
        check_eq("bp_pending_samples", in_q.size(), 1);
        out_prob  = 100;
        out_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            check_eq("bp_gapfree_valid", out_valid, 1);
            run_cycle();
        end
        run_idle(50);

        // Reset mid-block with a full output buffer pending
        out_prob = 0;
        add_samples(1'b0, blk);
        push_exp(16'd284, 1'b0);
        for (int j = 1; j < 8; j++) push_exp(16'd0, 1'b0);
        for (int j = 0; j < 5; j++) begin
            smp_t e;
            e.d   = 16'($urandom);
            e.inv = 1'b0;
            in_q.push_back(e);
        end
        drive();
        repeat (14) run_cycle();
        check_eq("pre_rst_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1 check_reset_vals();
        in_q.delete();
        exp_q.delete();
        exp_idx  = 0;
        out_prob = 100;
        @(posedge clk);
        #1 rst_n = 1'b1;
        blk[0] = 16'd256;
        for (int j = 1; j < 8; j++) blk[j] = 16'd0;
        add_samples(1'b0, blk);
        for (int j = 0; j < 8; j++) push_exp(16'(imp_f[j]), 1'b0);
        drive();
        run_idle(100);

        // Randomized blocks under varying handshake pressure
        for (int g = 0; g < 4; g++) begin
            logic inv;
            in_prob  = 30 + int'($urandom_range(70));
            out_prob = 30 + int'($urandom_range(70));
            for (int b = 0; b < 10; b++) begin
                case ($urandom_range(2))
                    0:       for (int j = 0; j < 8; j++) blk[j] = 16'($signed(int'($urandom_range(600)) - 300));
                    1:       for (int j = 0; j < 8; j++) blk[j] = 16'($urandom);
                    default: begin
                        blk[0] = 16'($urandom);
                        for (int j = 1; j < 8; j++) blk[j] = blk[0];
                    end
                endcase
                inv = 1'($urandom);
                add_samples(inv, blk);
                add_model(inv, blk);
            end
            drive();
            run_idle(3000);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dct8_stream_mac.md
Name: dct8_stream_mac

Overview:
- Streaming 8-point 1-D DCT-II / inverse DCT (DCT-III) engine for the image compression datapath.
- Replaces the 8-lane parallel transform with a sample-serial design: one sample per cycle in, one coefficient per cycle out.
- Uses ready/valid backpressure on both sides and double buffering, so input and output overlap at full rate.
- Two instances plus a transpose buffer form the 2-D transform.

Parameters:
- DATA_W, 16: signed width of input samples and output coefficients.
- CONST_W, 16: signed width of quantised cosine constants; must satisfy CONST_W > FRAC+1.
- FRAC, 8: fractional bits of the constants and the right-shift applied at output rounding.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  input sample accepted when in_valid && in_ready.
- in_data  in  DATA_W  signed sample; n-th accepted sample of a block is x[n] (forward) or y[k] (inverse).
- in_inv  in  1  mode, sampled only on the first sample of a block: 0 = forward, 1 = inverse.
- out_valid  out  1  output word valid.
- out_ready  in  1  output word consumed when out_valid && out_ready.
- out_data  out  DATA_W  signed result word.
- out_idx  out  3  index (0..7) of the current output word.
- out_last  out  1  high with out_idx==7.
- sat_o  out  1  current output word was clamped (feature-dependent).

Behaviour:
- Constants:
  - C[k][n] = round_half_away(2^FRAC * c(k)/2 * cos((2n+1)k*pi/16)), with c(0)=1/sqrt2 and c(k>0)=1.
  - Held as a CONST_W-bit signed ROM.
- Arithmetic:
  - Full-precision signed accumulators; ACC_W = DATA_W+CONST_W+3 (no overflow possible).
  - Forward: acc[k] += C[k][n]*x[n] for n = 0..7.
  - Inverse: acc[n] += C[k][n]*y[k] for k = 0..7.
  - Result r = (acc + 2^(FRAC-1)) >>> FRAC (arithmetic shift, round half up), then reduced to DATA_W per the Optional Feature.
  - Output is bit-exact to this formula.
- Input side:
  - 3-bit counter cnt counts accepted samples; 8 MAC lanes update on every handshake.
  - Mode is latched when cnt==0 and held for the rest of the block.
  - Accumulators clear on the handshake at cnt==0 (acc = product).
- Block completion:
  - On the handshake at cnt==7, the rounded final sums (acc + current product) load into the output buffer and cnt wraps to 0.
- Output buffer:
  - 8 words plus obuf_valid; drains index 0..7, one word per out handshake.
  - obuf_valid clears after the out_idx==7 handshake unless a new block loads in the same cycle.
- in_ready:
  - in_ready = (cnt!=7) || !obuf_valid || (out_valid && out_ready && out_last).
  - This is a combinational out_ready->in_ready path.
  - A simultaneous final drain and final load is legal and yields gap-free output.
- Latency and throughput:
  - out_valid with out_idx=0 rises the cycle after the 8th input handshake.
  - Sustained throughput is 1 sample/cycle in and 1 word/cycle out.
- Output hold rule: out_data, out_idx and out_last are stable while out_valid && !out_ready.
- Reset (asynchronous, any time, including mid-block):
  - cnt=0, mode=0, accumulators and buffer cleared, obuf_valid=0.
  - Outputs: out_valid=0, out_data=0, out_idx=0, out_last=0, sat_o=0, in_ready=1.
  - Any partial block is discarded.
- in_valid low mid-block: cnt holds; the block resumes with no loss.

Optional Feature:
- Macro DCT8_STREAM_SAT_EN.
- Defined:
  - Result clamps to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - sat_o is high for each output word that was clamped; the flag is stored per word in the buffer.
- Undefined:
  - Result is truncated to its low DATA_W bits (two's-complement wrap).
  - sat_o is tied 0 and no clamp logic is generated.

Test Plan:
- DC, forward, defaults: eight samples of 100 -> words 284,0,0,0,0,0,0,0; out_valid rises one cycle after the 8th handshake; out_last only on idx 7.
- Impulse, forward: x = 256,0,0,0,0,0,0,0 -> words 91,126,118,106,91,71,49,25.
- Impulse, inverse: in_inv=1 on first sample, y = 256,0,...,0 -> eight words of 91. Then a forward block immediately after -> mode switches per block.
- Overflow: eight samples of 32767, forward.
  - With DCT8_STREAM_SAT_EN: word 0 = 32767 with sat_o=1.
  - Without it: word 0 = 27645 with sat_o=0.
- Backpressure: out_ready=0 while two DC blocks are offered -> in_ready drops at the second block's 8th sample. Raising out_ready -> first block drains; the second loads in the same cycle as the first block's last handshake; no gap, no loss.
- Reset mid-block: rst_n low after 5 samples -> all outputs return to reset values immediately. A following impulse block -> 91,126,118,106,91,71,49,25 with no contamination from the discarded partial block.
